// File: rtl/spi_controller_if.sv
// Request handshake between a sequencer and spi_controller.
// master = request source, slave = spi_controller.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: turns register-write requests into 16-bit frames
// {rw, addr[6:0], data[7:0]}, sent MSB first on sclk/copi/ncs.
// Optional readback of cipo into rx_data is enabled by SPI_CTRL_READBACK_EN.
module spi_controller #(
    parameter int CLK_DIV  = 4,   // sclk half-period in clk cycles
    parameter int CS_SETUP = 4,   // ncs fall to first sclk rise
    parameter int CS_GAP   = 8    // ncs high time before done/req_ready
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_controller_if.slave         req,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    copi,
    output logic                    ncs,
    input  logic                    cipo,
    output logic [7:0]              rx_data
);

    // One shared down-counter times every phase; size it to the longest one.
    localparam int MAXC = (CLK_DIV > CS_SETUP)
                        ? ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP)
                        : ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP);
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_controller: CLK_DIV must be >= 2");
    end
    if (CS_SETUP < 1) begin : g_bad_cs_setup
        $error("spi_controller: CS_SETUP must be >= 1");
    end
    if (CS_GAP < 1) begin : g_bad_cs_gap
        $error("spi_controller: CS_GAP must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [15:0]   sh_q;
    logic          sclk_q;
    logic          copi_q;
    logic          ncs_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;

    // End of an sclk-high phase: the cycle the peripheral-facing data is sampled.
    logic          hi_end;
    // Final GAP cycle: next cycle is the done cycle.
    logic          gap_end;

    assign hi_end  = (state_q == S_SHIFT) && sclk_q && (cnt_q == '0);
    assign gap_end = (state_q == S_GAP) && (cnt_q == '0);

    assign req.req_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sclk          = sclk_q;
    assign copi          = copi_q;
    assign ncs           = ncs_q;

    // Frame sequencer: all outputs registered, phases timed by cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req.req_valid && ready_q) begin
                        sh_q    <= {req.req_rw, req.req_addr, req.req_data};
                        copi_q  <= req.req_rw;
                        ncs_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(CS_SETUP - 1);
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        sclk_q  <= 1'b1;
                        bit_q   <= '0;
                        cnt_q   <= CW'(CLK_DIV - 1);
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (sclk_q) begin
                        // Falling edge: advance copi, or enter HOLD after bit 0.
                        sclk_q <= 1'b0;
                        cnt_q  <= CW'(CLK_DIV - 1);
                        if (bit_q == 4'd15) begin
                            state_q <= S_HOLD;
                        end else begin
                            sh_q   <= {sh_q[14:0], 1'b0};
                            copi_q <= sh_q[14];
                            bit_q  <= bit_q + 4'd1;
                        end
                    end else begin
                        sclk_q <= 1'b1;
                        cnt_q  <= CW'(CLK_DIV - 1);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        ncs_q   <= 1'b1;
                        copi_q  <= 1'b0;
                        cnt_q   <= CW'(CS_GAP - 1);
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_CTRL_READBACK_EN
    logic [15:0] rx_sh_q;
    logic [7:0]  rx_q;

    assign rx_data = rx_q;

    // Capture cipo at the end of each sclk-high phase; publish the data byte with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_q <= '0;
            rx_q    <= '0;
        end else begin
            if (hi_end) begin
                rx_sh_q <= {rx_sh_q[14:0], cipo};
            end
            if (gap_end) begin
                rx_q <= rx_sh_q[7:0];
            end
        end
    end
`else
    logic unused_rx;

    assign unused_rx = cipo ^ hi_end ^ gap_end;
    assign rx_data   = 8'h00;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Randomized self-checking bench for spi_controller. A frame-level monitor
// decodes ncs/sclk/copi, plays a simple register-file peripheral and drives
// cipo with a chosen response word.
module tb_spi_controller;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_GAP   = 8;
    localparam int LOW_CYC  = CS_SETUP + 32 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, done, sclk, copi, ncs, cipo;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_controller_if rq();

    spi_controller #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rq),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .copi   (copi),
        .ncs    (ncs),
        .cipo   (cipo),
        .rx_data(rx_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- frame monitor / peripheral model ----------------
    int          cyc = 0, low_cnt = 0, hi_cnt = 0, last_low = 0, last_hi = 0;
    int          nbits = 0, falls = 0, last_bits = 0, done_cnt = 0;
    int          sclk_err = 0, rise_cyc = 0, done_delay = 0;
    logic [15:0] cap = '0, last_cap = '0, resp = '0;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
    logic [7:0]  pmem    [128];
    logic [7:0]  ref_mem [128];

    // Peripheral shifts its response out MSB first, changing after each sclk fall.
    assign cipo = (!ncs && falls < 16) ? resp[4'(15 - falls)] : 1'b0;

    // Observe the serial bus once per cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!ncs) begin
            if (prev_ncs) begin
                low_cnt = 0; nbits = 0; falls = 0; cap = '0; last_hi = hi_cnt;
            end
            low_cnt++;
            if (sclk && !prev_sclk) begin
                cap = {cap[14:0], copi};
                nbits++;
            end
            if (!sclk && prev_sclk) falls++;
        end else begin
            if (!prev_ncs) begin
                last_low = low_cnt; last_bits = nbits; last_cap = cap;
                rise_cyc = cyc; hi_cnt = 0;
                if (nbits == 16 && cap[15]) pmem[cap[14:8]] = cap[7:0];
            end
            hi_cnt++;
            if (sclk && !prev_sclk) sclk_err++;
        end
        if (done) begin
            done_cnt++;
            done_delay = cyc - rise_cyc;
        end
        prev_ncs  = ncs;
        prev_sclk = sclk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rw, input logic [6:0] a, input logic [7:0] d);
        rq.req_valid = 1'b1;
        rq.req_rw    = rw;
        rq.req_addr  = a;
        rq.req_data  = d;
    endtask

    // Present a request at a negedge and wait for it to be accepted.
    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                        input logic hold_valid);
        int n = 0;
        drive(rw, a, d);
        while (!rq.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold_valid) rq.req_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 1);
        chk("ready_after_accept", {31'd0, rq.req_ready}, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("done_timeout", 0, 1);
        #1;
    endtask

    function automatic logic [7:0] exp_rx(input logic [15:0] r);
`ifdef SPI_CTRL_READBACK_EN
        return r[7:0];
`else
        return 8'h00 & r[7:0];
`endif
    endfunction

    // Compare the frame just finished against the request that produced it.
    task automatic check_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                               input logic [15:0] r);
        chk("frame_bits", last_cap, {16'd0, rw, a, d});
        chk("sclk_rises", last_bits, 16);
        chk("ncs_low_cycles", last_low, LOW_CYC);
        chk("done_after_ncs_rise", done_delay, CS_GAP);
        chk("ready_in_done", {31'd0, rq.req_ready}, 1);
        chk("busy_in_done", {31'd0, busy}, 0);
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx(r)});
    endtask

    task automatic run_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                             input logic [15:0] r);
        int dc0;
        resp = r;
        dc0 = done_cnt;
        send(rw, a, d, 1'b0);
        wait_done();
        if (rw) ref_mem[a] = d;
        check_frame(rw, a, d, r);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("pmem", {24'd0, pmem[a]}, {24'd0, ref_mem[a]});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dc;
        logic        rw;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] r;

        for (int i = 0; i < 128; i++) begin
            pmem[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rq.req_valid = 1'b0;
        rq.req_rw    = 1'b0;
        rq.req_addr  = '0;
        rq.req_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sclk", {31'd0, sclk}, 0);
        chk("rst_copi", {31'd0, copi}, 0);
        chk("rst_ncs", {31'd0, ncs}, 1);
        chk("rst_ready", {31'd0, rq.req_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rx", {24'd0, rx_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, response carries 0x3C in its data byte
        run_frame(1'b1, 7'h00, 8'hA5, 16'hC33C);

        // Back-to-back with req_valid held high
        resp = 16'h5AE1;
        dc = done_cnt;
        send(1'b1, 7'h01, 8'hFF, 1'b1);
        drive(1'b1, 7'h04, 8'h00);
        wait_done();
        ref_mem[1] = 8'hFF;
        check_frame(1'b1, 7'h01, 8'hFF, 16'h5AE1);
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        chk("b2b_second_accept", {31'd0, busy}, 1);
        resp = 16'h0F96;
        wait_done();
        ref_mem[4] = 8'h00;
        check_frame(1'b1, 7'h04, 8'h00, 16'h0F96);
        chk("b2b_ncs_high", last_hi, CS_GAP + 1);
        chk("b2b_done_pulses", done_cnt - dc, 2);
        @(negedge clk);

        // Loopback: write then a read frame that must not modify the register
        run_frame(1'b1, 7'h00, 8'hF0, 16'h1234);
        run_frame(1'b0, 7'h00, 8'h0F, 16'h00AA);
        chk("loopback_reg0", {24'd0, pmem[0]}, 32'hF0);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            d  = 8'($urandom);
            r  = 16'($urandom);
            run_frame(rw, a, d, r);
        end

        // Reset mid-frame after the 5th sclk rise
        resp = 16'hFFFF;
        send(1'b1, 7'h33, 8'h77, 1'b0);
        begin
            int n = 0;
            while (nbits < 5 && n < 1000) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= 1000) chk("midrst_timeout", 0, 1);
        end
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_ncs", {31'd0, ncs}, 1);
        chk("midrst_sclk", {31'd0, sclk}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_ready", {31'd0, rq.req_ready}, 1);
        chk("midrst_rx", {24'd0, rx_data}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc, 0);
        chk("midrst_no_write", {24'd0, pmem[7'h33]}, {24'd0, ref_mem[7'h33]});
        run_frame(1'b1, 7'h02, 8'h55, 16'hA53C);

        chk("sclk_while_ncs_high", sclk_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 controller (initiator) that turns parallel register-write requests into 16-bit serial frames on sclk/copi/ncs.
- Drives the team's SPI peripheral register block from an on-chip sequencer or test harness, replacing an external SPI master.
- Frame format is MSB first: {rw[15], addr[14:8], data[7:0]}.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles; must be >= 2 so the peripheral's 2-FF synchroniser sees every edge.
- CS_SETUP, 4: clk cycles from ncs fall to the first sclk rise; must be >= 1.
- CS_GAP, 8: minimum clk cycles ncs stays high after a frame before done/req_ready; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_rw  in  1  frame bit 15 (1 = write)
- req_addr  in  7  frame bits 14:8
- req_data  in  8  frame bits 7:0
- busy  out  1  frame in progress (accept cycle through end of gap)
- done  out  1  one-cycle pulse at end of frame plus gap
- sclk  out  1  SPI clock, idles low
- copi  out  1  serial data to the peripheral
- ncs  out  1  chip select, active low
- cipo  in  1  serial data from the peripheral; used only with the optional feature
- rx_data  out  8  captured read byte

Behaviour:
- Reset values: sclk=0, copi=0, ncs=1, req_ready=1, busy=0, done=0, rx_data=0. All outputs are registered.
- Reset asserted mid-frame forces all outputs to reset values immediately. No done pulse is issued and the partial frame is discarded.
- Accept on the posedge where req_valid && req_ready:
  - latch {req_rw, req_addr, req_data} into a 16-bit shift register;
  - next cycle: req_ready=0, busy=1.
  - Request inputs are ignored at all other times.
- States and transitions:
  - IDLE -> SETUP (on accept)
  - SETUP -> SHIFT -> HOLD -> GAP -> IDLE
- SETUP, CS_SETUP cycles: ncs=0, sclk=0, copi=bit15.
- SHIFT, 16 bits:
  - each bit is sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles;
  - copi advances to the next bit in the same cycle sclk falls;
  - a 4-bit bit counter runs 0..15.
  - The low phase after bit 0 (the 16th bit) is HOLD, not SHIFT.
- HOLD, CLK_DIV cycles: sclk=0, ncs=0, copi holds bit0.
- GAP, CS_GAP cycles: ncs=1, copi=0.
  - On the final GAP cycle the state returns to IDLE; the next cycle has done=1, req_ready=1, busy=0 simultaneously.
- Timing at defaults:
  - ncs low time = CS_SETUP + 32*CLK_DIV = 132 cycles;
  - exactly 16 sclk rising edges per frame; no sclk edges while ncs=1.
- Back-to-back: if req_valid is high in the done cycle, the new request is accepted in that cycle. ncs high time between frames = CS_GAP+1 cycles.
- Counter widths are sized to the parameters; parameter values below the stated minimums are a configuration error.

Optional Feature:
- Macro SPI_CTRL_READBACK_EN.
- Defined:
  - cipo is sampled on the last clk cycle of each sclk-high phase and shifted into a 16-bit rx shift register (first sample lands in the MSB);
  - rx_data is updated with rx_shift[7:0] in the done cycle and held until the next done or reset.
- Undefined: cipo is unused, rx_data is constant 0, and no rx registers exist.

Test Plan:
- Reset: hold rst_n=0 -> sclk=0, copi=0, ncs=1, req_ready=1, busy=0, done=0, rx_data=0.
- Single write rw=1, addr=0x00, data=0xA5 -> copi sampled at 16 sclk rises = 1,0000000,10100101; ncs low 132 cycles; exactly one done pulse CS_GAP cycles after ncs rises.
- Back-to-back, req_valid held high: (1, 0x01, 0xFF) then (1, 0x04, 0x00) -> both frames correct; ncs high exactly 9 cycles between them; two done pulses.
- Loopback into the team's SPI peripheral: write addr 0x00 data 0xF0 -> peripheral register 0 reads 0xF0 after the frame; a frame with rw=0 leaves it unchanged.
- Reset mid-frame, asserted after the 5th sclk rise -> ncs=1 and sclk=0 asynchronously, no done; after release a new request (1, 0x02, 0x55) completes correctly.
- With SPI_CTRL_READBACK_EN: model drives cipo with 0x3C in the data phase -> rx_data=0x3C in the done cycle. Without the macro, rx_data stays 0.
